skew_monitor: RTL

//  Synthesizable, multi-channel successor to the bench-only tx/rx clock-skew check.

---
 rtl/skew_mon_pkg.sv | 12 +
 rtl/skew_chan.sv | 73 +++++++
 rtl/skew_monitor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/skew_mon_pkg.sv
// Shared state encoding and helpers for the skew monitor.
// Pure declarations: no timing or flow control.
package skew_mon_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} skew_state_t;

   // All-ones value for a result of the given width; marks a channel that never arrived.
   function automatic logic [31:0] SKEW_TIMEOUT_VAL(input int width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/skew_chan.sv
// One monitored channel: rise detect, single capture per measurement, held result, window check.
// Result is published on the cycle the measurement ends; no backpressure.
module skew_chan
   import skew_mon_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int MIN_SKEW = 1,
   parameter int MAX_SKEW = 3
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ch,
   input  logic             start,
   input  logic             measuring,
   input  logic             timeout,
   input  logic             load,
   input  logic             done,
   input  logic             clear,
   input  logic [CNT_W-1:0] cnt_val,
   output logic             cap_next,
   output logic [CNT_W-1:0] skew,
   output logic             err
);

   localparam logic [CNT_W-1:0] TO_MARK = CNT_W'(SKEW_TIMEOUT_VAL(CNT_W));
   localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_SKEW);
   localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_SKEW);

   logic             prev;
   logic             captured;
   logic             take;
   logic             bad;
   logic [CNT_W-1:0] result;
   logic [CNT_W-1:0] res_next;

   always_comb begin
      // A new measurement discards the previous captured flag, so stale captures never leak forward.
      take     = ch & ~prev & (start | (measuring & ~captured));
      cap_next = take | (captured & ~start);
      res_next = result;
      if (take) begin
         res_next = cnt_val;
      end else if (measuring & timeout & ~captured) begin
         res_next = TO_MARK;
      end
      bad = (skew < MIN_V) | (skew > MAX_V) | (skew == TO_MARK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= 1'b0;
         captured <= 1'b0;
         result   <= '0;
         skew     <= '0;
         err      <= 1'b0;
      end else begin
         prev     <= ch;
         captured <= cap_next;
         result   <= res_next;
         if (load) begin
            skew <= res_next;
         end
         // Clear wins over an error raised in the same completion cycle.
         if (clear) begin
            err <= 1'b0;
         end else if (done & bad) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/skew_monitor.sv
// Measures reference-to-channel strobe delay per channel; doneOut pulses 1 cycle after the last capture or the timeout cycle.
// Free-running, no backpressure; optional running min/max statistics under SKEW_MON_STATS_EN.
module skew_monitor
   import skew_mon_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int MIN_SKEW = 1,
   parameter int MAX_SKEW = 3,
   parameter int TIMEOUT  = 200
)
(
   input  logic                    clkIn,
   input  logic                    rstIn,
   input  logic                    enIn,
   input  logic                    clearIn,
   input  logic                    refIn,
   input  logic [NUM_CH-1:0]       chIn,
   output logic [NUM_CH*CNT_W-1:0] skewOut,
   output logic [NUM_CH-1:0]       errOut,
   output logic                    busyOut,
   output logic                    doneOut,
   output logic [CNT_W-1:0]        minSkewOut,
   output logic [CNT_W-1:0]        maxSkewOut
);

   localparam logic [CNT_W-1:0] TO_MARK   = CNT_W'(SKEW_TIMEOUT_VAL(CNT_W));
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

   skew_state_t       state;
   skew_state_t       state_next;
   logic              ref_prev;
   logic              ref_rise;
   logic              start;
   logic              measuring;
   logic              timeout;
   logic              load;
   logic              all_cap;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_val;
   logic [NUM_CH-1:0] cap_next;

   assign ref_rise  = refIn & ~ref_prev;
   assign measuring = (state == MEASURE);
   assign start     = (state == ARMED) & enIn & ref_rise;
   assign timeout   = (cnt == TIMEOUT_V);
   assign cnt_val   = start ? '0 : cnt;
   assign all_cap   = &cap_next;
   assign load      = measuring & (state_next == DONE);
   assign busyOut   = (state == ARMED) | (state == MEASURE);
   assign doneOut   = (state == DONE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enIn) state_next = ARMED;
         ARMED: begin
            if (!enIn) begin
               state_next = IDLE;
            end else if (ref_rise) begin
               state_next = MEASURE;
            end
         end
         MEASURE: if (all_cap || timeout) state_next = DONE;
         DONE:    state_next = enIn ? ARMED : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state    <= IDLE;
         ref_prev <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_next;
         ref_prev <= refIn;
         if (start) begin
            cnt <= CNT_W'(1);
         end else if (measuring) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      skew_chan #(
         .CNT_W    (CNT_W),
         .MIN_SKEW (MIN_SKEW),
         .MAX_SKEW (MAX_SKEW)
      ) u_chan (
         .clk       (clkIn),
         .rst       (rstIn),
         .ch        (chIn[gi]),
         .start     (start),
         .measuring (measuring),
         .timeout   (timeout),
         .load      (load),
         .done      (doneOut),
         .clear     (clearIn),
         .cnt_val   (cnt_val),
         .cap_next  (cap_next[gi]),
         .skew      (skewOut[gi*CNT_W +: CNT_W]),
         .err       (errOut[gi])
      );
   end

`ifdef SKEW_MON_STATS_EN
   logic [CNT_W-1:0] min_q;
   logic [CNT_W-1:0] max_q;
   logic [CNT_W-1:0] run_min;
   logic [CNT_W-1:0] run_max;
   logic [CNT_W-1:0] s;

   // Timed-out channels carry the marker value and are excluded from the statistics.
   always_comb begin
      run_min = min_q;
      run_max = max_q;
      s       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         s = skewOut[i*CNT_W +: CNT_W];
         if (s != TO_MARK) begin
            if (s < run_min) run_min = s;
            if (s > run_max) run_max = s;
         end
      end
   end

   always_ff @(posedge clkIn) begin
      if (rstIn || clearIn) begin
         min_q <= TO_MARK;
         max_q <= '0;
      end else if (doneOut) begin
         min_q <= run_min;
         max_q <= run_max;
      end
   end

   assign minSkewOut = min_q;
   assign maxSkewOut = max_q;
`else
   assign minSkewOut = TO_MARK;
   assign maxSkewOut = '0;
`endif

endmodule
